// File: rtl/ahb_lite_cpu_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// ahb_lite_cpu_master - one CPU load/store to one AHB-Lite SINGLE transfer (rev 1.0)
//------------------------------------------------------------------------------
module ahb_lite_cpu_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_func3,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int WD_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_func3;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_next;
  logic                  r_err, w_err_next;
  logic [WD_WIDTH-1:0]   r_wd, w_wd_next;
  logic                  w_accept;
  logic                  w_misaligned, w_illegal;
  logic [DATA_WIDTH-1:0] w_lane_data, w_load_ext, w_store_rep;

  always_comb begin
    w_misaligned = 1'b0;
    case (cpu_func3[1:0])
      2'b01:   w_misaligned = cpu_addr[0];
      2'b10:   w_misaligned = |cpu_addr[1:0];
      2'b11:   w_misaligned = |cpu_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
    w_illegal = w_misaligned
             || (!cpu_we && (cpu_func3 == 3'b111))
             || (cpu_we && cpu_func3[2])
             || ((DATA_WIDTH == 32) && ((cpu_func3 == 3'b011) || (cpu_func3 == 3'b110)));
  end

  // Selected lane is shifted down to bit 0 before extension.
  always_comb begin
    w_lane_data = HRDATA >> {r_addr[LANE_BITS-1:0], 3'b000};
    case (r_func3)
      3'b000:  w_load_ext = DATA_WIDTH'(signed'(w_lane_data[7:0]));
      3'b001:  w_load_ext = DATA_WIDTH'(signed'(w_lane_data[15:0]));
      3'b010:  w_load_ext = DATA_WIDTH'(signed'(w_lane_data[31:0]));
      3'b100:  w_load_ext = DATA_WIDTH'(w_lane_data[7:0]);
      3'b101:  w_load_ext = DATA_WIDTH'(w_lane_data[15:0]);
      3'b110:  w_load_ext = DATA_WIDTH'(w_lane_data[31:0]);
      default: w_load_ext = w_lane_data;
    endcase
  end

  always_comb begin
    case (r_func3[1:0])
      2'b00:   w_store_rep = {(DATA_WIDTH / 8){r_wdata[7:0]}};
      2'b01:   w_store_rep = {(DATA_WIDTH / 16){r_wdata[15:0]}};
      2'b10:   w_store_rep = {(DATA_WIDTH / 32){r_wdata[31:0]}};
      default: w_store_rep = r_wdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_wd_next    = r_wd;
    w_err_next   = r_err;
    w_rdata_next = r_rdata;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_wd_next = '0;
        if (cpu_req) begin
          if (w_illegal) begin
            w_state_next = DONE;
            w_err_next   = 1'b1;
          end else begin
            w_state_next = ADDR;
            w_accept     = 1'b1;
          end
        end
      end
      ADDR: begin
        if (HREADY) begin
          w_state_next = DATA;
          w_wd_next    = '0;
        end else if (r_wd == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = DONE;
          w_err_next   = 1'b1;
          w_wd_next    = '0;
        end else begin
          w_wd_next = r_wd + WD_WIDTH'(1);
        end
      end
      DATA: begin
        // An ERROR response only counts on its second (HREADY high) cycle.
        if (HREADY) begin
          w_state_next = DONE;
          w_wd_next    = '0;
          w_err_next   = HRESP;
          if (!HRESP && !r_we) begin
            w_rdata_next = w_load_ext;
          end
        end else if (r_wd == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = DONE;
          w_err_next   = 1'b1;
          w_wd_next    = '0;
        end else begin
          w_wd_next = r_wd + WD_WIDTH'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_func3 <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
      r_wd    <= w_wd_next;
      if (w_accept) begin
        r_addr  <= cpu_addr;
        r_func3 <= cpu_func3;
        r_we    <= cpu_we;
        r_wdata <= cpu_wdata;
      end
    end
  end

  assign HTRANS    = (r_state == ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = (r_state == ADDR) ? r_addr : '0;
  assign HWRITE    = (r_state == ADDR) && r_we;
  assign HSIZE     = (r_state == ADDR) ? {1'b0, r_func3[1:0]} : 3'b000;
  assign HBURST    = 3'b000;
  assign HWDATA    = ((r_state == DATA) && r_we) ? w_store_rep : '0;
  assign cpu_busy  = (r_state == ADDR) || (r_state == DATA);
  assign cpu_done  = (r_state == DONE);
  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_cpu_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ahb_lite_cpu_master - randomized bench with transaction-level timeline model (rev 1.0)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_lite_cpu_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_func3 = 3'b000;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, HADDR, HWDATA;
  logic [31:0] HRDATA = 32'd0;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  ahb_lite_cpu_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_func3(cpu_func3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Per-cycle expectations written by the driver, consumed by the compare process.
  bit          chk_en = 0, chk_addr = 0, chk_wdata = 0, chk_result = 0, chk_rst = 0;
  logic [1:0]  exp_htrans = 2'b00;
  logic        exp_busy = 0, exp_done = 0, exp_err = 0, exp_hwrite = 0;
  logic [31:0] exp_haddr = 0, exp_hwdata = 0, exp_rdata = 0;
  logic [2:0]  exp_hsize = 0;
  logic [31:0] mdl_rdata = 0;
  int          cur_k = 0;
  int          obs_done_k = -1;
  logic [31:0] obs_hwdata = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", nm, act, exp, cur_k, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("htrans", 64'(HTRANS), 64'(exp_htrans));
      chk("hburst", 64'(HBURST), 64'd0);
      chk("busy", 64'(cpu_busy), 64'(exp_busy));
      chk("done", 64'(cpu_done), 64'(exp_done));
      chk("rdata", 64'(cpu_rdata), 64'(exp_rdata));
      if (chk_addr) begin
        chk("haddr", 64'(HADDR), 64'(exp_haddr));
        chk("hwrite", 64'(HWRITE), 64'(exp_hwrite));
        chk("hsize", 64'(HSIZE), 64'(exp_hsize));
      end
      if (chk_wdata) begin
        chk("hwdata", 64'(HWDATA), 64'(exp_hwdata));
        obs_hwdata = HWDATA;
      end
      if (chk_result) chk("err", 64'(cpu_err), 64'(exp_err));
      if (chk_rst) begin
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwrite", 64'(HWRITE), 64'd0);
        chk("rst_hsize", 64'(HSIZE), 64'd0);
        chk("rst_hwdata", 64'(HWDATA), 64'd0);
        chk("rst_err", 64'(cpu_err), 64'd0);
      end
      if (cpu_done) obs_done_k = cur_k;
    end
  end

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] s, v;
    s = d >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin v = s & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = s & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd4: v = s & 32'hFF;
      3'd5: v = s & 32'hFFFF;
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  task automatic clear_flags();
    chk_addr = 0; chk_wdata = 0; chk_result = 0; chk_rst = 0;
  endtask

  task automatic idle(input int n, input bit rstchk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      cur_k = -1;
      cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_func3 = 3'($urandom);
      cpu_addr = $urandom; cpu_wdata = $urandom;
      HREADY = 1'($urandom); HRESP = 1'b0; HRDATA = $urandom;
      clear_flags();
      chk_rst = rstchk;
      exp_htrans = 2'b00; exp_busy = 0; exp_done = 0; exp_rdata = mdl_rdata;
    end
  endtask

  // Timeline: cycle 0 presents the request; all other cycle numbers count from it.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int aw, input int dw, input logic er);
    bit ill, tmo, e, in_a, in_d;
    int addr_last, d0, done_c;
    logic [31:0] ext, rep;
    ill = (!we && f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (we && f3[2])
        || ((a % (32'd1 << f3[1:0])) != 0);
    tmo = 0; d0 = 0; addr_last = 0;
    if (ill) done_c = 1;
    else if (aw >= TO) begin addr_last = TO; done_c = 1 + TO; tmo = 1; end
    else begin
      addr_last = 1 + aw;
      d0 = 2 + aw;
      if (dw >= TO) begin done_c = d0 + TO; tmo = 1; end
      else done_c = d0 + dw + 1;
    end
    e = er && !ill && !tmo;
    ext = load_ext(f3, a, rd);
    rep = store_rep(f3, wd);
    obs_done_k = -1;
    for (int k = 0; k <= done_c; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      in_a = (k >= 1) && (k <= addr_last);
      in_d = (d0 > 0) && (k >= d0) && (k < done_c);
      if (k == 0) begin
        cpu_req = 1'b1; cpu_we = we; cpu_func3 = f3; cpu_addr = a; cpu_wdata = wd;
      end else begin
        cpu_req = (k < done_c) ? 1'($urandom) : 1'b0;
        cpu_we = 1'($urandom); cpu_func3 = 3'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (in_a)      HREADY = (k == 1 + aw);
      else if (in_d) HREADY = (k == d0 + dw);
      else           HREADY = 1'($urandom);
      HRESP  = e && in_d && (k >= d0 + dw - 1);
      HRDATA = (in_d && k == d0 + dw) ? rd : $urandom;
      clear_flags();
      exp_htrans = in_a ? 2'b10 : 2'b00;
      exp_busy   = (k >= 1) && (k < done_c);
      exp_done   = (k == done_c);
      chk_addr   = in_a;
      exp_haddr  = a; exp_hwrite = we; exp_hsize = {1'b0, f3[1:0]};
      chk_wdata  = we && in_d;
      exp_hwdata = rep;
      if (k == done_c) begin
        chk_result = 1;
        exp_err = ill || tmo || e;
        if (!we && !ill && !tmo && !e) mdl_rdata = ext;
      end
      exp_rdata = mdl_rdata;
    end
    @(negedge clk); #1;
  endtask

  task automatic reset_mid();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      cpu_req = (k == 0); cpu_we = 1'b0; cpu_func3 = 3'b010;
      cpu_addr = 32'hB000_0008; cpu_wdata = $urandom;
      HREADY = (k == 1); HRESP = 1'b0; HRDATA = $urandom;
      clear_flags();
      exp_htrans = (k == 1) ? 2'b10 : 2'b00;
      exp_busy = (k >= 1); exp_done = 0; exp_rdata = mdl_rdata;
      chk_addr = (k == 1); exp_haddr = 32'hB000_0008; exp_hwrite = 0; exp_hsize = 3'b010;
      if (k == 3) reset = 1'b1;
    end
    mdl_rdata = 32'd0;
    obs_done_k = -1;
    idle(1, 1);
    idle(3, 0);
    @(negedge clk); #1;
    chk("rst_no_done", 64'(obs_done_k), 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic random_txn();
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    int aw, dw, t;
    logic e;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 8) begin
      t = int'($urandom_range(0, we ? 2 : 4));
      f3 = 3'((t > 2) ? t + 1 : t);
    end else f3 = 3'($urandom);
    a = ($urandom_range(0, 1) != 0 ? 32'hA000_0000 : 32'hB000_0000) | 32'($urandom_range(0, 65535));
    if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
    aw = ($urandom_range(0, 19) < 18) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 18));
    dw = ($urandom_range(0, 19) < 18) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 18));
    e = ($urandom_range(0, 5) == 0) && (dw > 0);
    run_txn(we, f3, a, $urandom, $urandom, aw, dw, e);
    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    clear_flags();
    chk_rst = 1; exp_htrans = 2'b00; exp_busy = 0; exp_done = 0; exp_rdata = 32'd0;
    chk_en = 1;
    idle(1, 1);
    idle(2, 0);

    run_txn(1'b0, 3'b010, 32'hB000_0004, 32'd0, 32'h1234_5678, 0, 0, 1'b0);
    chk("lw_done_cycle", 64'(obs_done_k), 64'd3);
    chk("lw_rdata", 64'(cpu_rdata), 64'h1234_5678);
    chk("lw_err", 64'(cpu_err), 64'd0);
    run_txn(1'b0, 3'b000, 32'hB000_0003, 32'd0, 32'h80FF_0000, 0, 0, 1'b0);
    chk("lb_rdata", 64'(cpu_rdata), 64'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'hB000_0003, 32'd0, 32'h80FF_0000, 0, 0, 1'b0);
    chk("lbu_rdata", 64'(cpu_rdata), 64'h0000_0080);
    run_txn(1'b0, 3'b001, 32'hB000_0002, 32'd0, 32'h80FF_0000, 0, 0, 1'b0);
    chk("lh_rdata", 64'(cpu_rdata), 64'hFFFF_80FF);
    run_txn(1'b1, 3'b001, 32'hB000_0002, 32'h0000_ABCD, 32'd0, 0, 0, 1'b0);
    chk("sh_hwdata", 64'(obs_hwdata), 64'hABCD_ABCD);
    chk("sh_err", 64'(cpu_err), 64'd0);
    run_txn(1'b1, 3'b000, 32'hB000_0005, 32'h0000_0012, 32'd0, 0, 0, 1'b0);
    chk("sb_hwdata", 64'(obs_hwdata), 64'h1212_1212);
    run_txn(1'b0, 3'b010, 32'hB000_0002, 32'd0, 32'd0, 0, 0, 1'b0);
    chk("misalign_done_cycle", 64'(obs_done_k), 64'd1);
    chk("misalign_err", 64'(cpu_err), 64'd1);
    run_txn(1'b0, 3'b011, 32'hB000_0000, 32'd0, 32'd0, 0, 0, 1'b0);
    chk("ld32_done_cycle", 64'(obs_done_k), 64'd1);
    chk("ld32_err", 64'(cpu_err), 64'd1);
    run_txn(1'b0, 3'b010, 32'hB000_0010, 32'd0, 32'hCAFE_BABE, 0, 3, 1'b0);
    chk("wait3_done_cycle", 64'(obs_done_k), 64'd6);
    chk("wait3_rdata", 64'(cpu_rdata), 64'hCAFE_BABE);
    run_txn(1'b0, 3'b010, 32'hB000_0014, 32'd0, 32'h1111_1111, 0, 1, 1'b1);
    chk("hresp_err", 64'(cpu_err), 64'd1);
    chk("hresp_rdata_kept", 64'(cpu_rdata), 64'hCAFE_BABE);
    run_txn(1'b0, 3'b010, 32'hA000_0000, 32'd0, 32'd0, 20, 0, 1'b0);
    chk("addr_tmo_done_cycle", 64'(obs_done_k), 64'd17);
    chk("addr_tmo_err", 64'(cpu_err), 64'd1);
    run_txn(1'b0, 3'b010, 32'hA000_0004, 32'd0, 32'd0, 0, 30, 1'b0);
    chk("data_tmo_done_cycle", 64'(obs_done_k), 64'd18);
    run_txn(1'b0, 3'b010, 32'hA000_0008, 32'd0, 32'h0BAD_F00D, 15, 15, 1'b0);
    chk("no_tmo_done_cycle", 64'(obs_done_k), 64'd33);
    chk("no_tmo_err", 64'(cpu_err), 64'd0);

    reset_mid();
    run_txn(1'b0, 3'b010, 32'hB000_000C, 32'd0, 32'h5A5A_0001, 0, 0, 1'b0);
    chk("post_rst_done_cycle", 64'(obs_done_k), 64'd3);
    chk("post_rst_rdata", 64'(cpu_rdata), 64'h5A5A_0001);

    for (int i = 0; i < 300; i++) random_txn();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish (checks %0d)", n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ahb_lite_cpu_master.md
Name: ahb_lite_cpu_master

Overview:
- Parametrised successor to the CPU load/store memory front end.
- Converts one CPU load/store request into a single AHB-Lite transfer. Covers byte, half, word and (when DATA_WIDTH=64) doubleword sizes.
- Provides HREADY wait-state handling, HRESP error capture, a wait-state watchdog and load sign/zero extension.
- Sits between the core's MEM stage and the AHB-Lite interconnect that decodes the ROM (0xA000_xxxx) and RAM (0xB000_xxxx) regions.

Parameters:
- ADDR_WIDTH, 32, width of cpu_addr and HADDR.
- DATA_WIDTH, 32, bus data width; legal values are 32 and 64.
- TIMEOUT_CYCLES, 16, maximum HREADY-low cycles tolerated in one phase before the transfer is aborted with an error.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only when cpu_busy=0.
- cpu_we  in  1  1=store, 0=load.
- cpu_func3  in  3  RISC-V funct3 size/sign code.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data, right-aligned.
- cpu_busy  out  1  high from the cycle after acceptance until the cycle cpu_done is asserted.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done; indicates misalignment, illegal func3, HRESP error or timeout.
- cpu_rdata  out  DATA_WIDTH  extended load data; valid with cpu_done and held until the next done.
- HADDR  out  ADDR_WIDTH  AHB address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB size; equals func3[1:0].
- HBURST  out  3  constant 000 (SINGLE).
- HWDATA  out  DATA_WIDTH  lane-replicated store data.
- HRDATA  in  DATA_WIDTH  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response; 1=ERROR.

Behaviour:
- Reset: state=IDLE. HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, cpu_busy=0, cpu_done=0, cpu_err=0, cpu_rdata=0, watchdog=0. Reset asserted mid-transfer abandons it immediately; no cpu_done is issued.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE, cpu_req=1, request legal: register addr/size/we/func3/wdata and go to ADDR. In the next cycle HTRANS=10 with HADDR/HWRITE/HSIZE driven.
- IDLE, cpu_req=1, request illegal: go to DONE with err=1; no bus transfer is issued.
- Illegal requests:
  - Load func3 111.
  - func3 011 or 110 when DATA_WIDTH=32.
  - Store with func3[2]=1.
  - Address not aligned to 2^func3[1:0] bytes.
- ADDR: hold the address-phase signals until HREADY=1. Then go to DATA with HTRANS=00; for stores, HWDATA is driven this cycle.
- DATA: wait for HREADY=1, then go to DONE.
  - Load: capture and extend HRDATA.
  - HRESP=1 sampled with HREADY=1: err=1.
  - HRESP=1 with HREADY=0 (first error cycle): no action.
- DONE: cpu_done=1 for one cycle, cpu_busy=0, then return to IDLE. A new cpu_req is accepted in the following IDLE cycle.
- Zero-wait latency: request accepted at cycle T → HTRANS=NONSEQ at T+1 → data phase at T+2 → cpu_done at T+3. Each HREADY-low cycle adds one cycle.
- Watchdog:
  - Counts consecutive HREADY-low cycles in ADDR or DATA; cleared on phase change.
  - When the count reaches TIMEOUT_CYCLES: go to DONE with err=1, HTRANS=00, rdata unchanged.
- Load lane select: lane = addr[log2(DATA_WIDTH/8)-1:0]. The selected byte/half/word is right-aligned.
  - func3 000/001/010: sign-extended.
  - func3 100/101/110: zero-extended.
  - func3 011: full 64-bit value.
- Store lane replication: the byte is replicated to every byte lane, the half to every half lane, the word to every word lane (on 64-bit).
- cpu_rdata is not updated on error; cpu_err is cleared on the next done without error.

Test Plan:
- LW at 0xB000_0004, HREADY=1, HRDATA=0x12345678 → HSIZE=010, HTRANS=10 at T+1, cpu_done at T+3, cpu_rdata=0x12345678, cpu_err=0.
- LB at 0xB000_0003 with HRDATA=0x80FF_0000 → cpu_rdata=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LH at 0xB000_0002 → 0xFFFF_80FF.
- SH at 0xB000_0002, cpu_wdata=0x0000_ABCD → HWRITE=1, HSIZE=001, HWDATA=0xABCD_ABCD in the data phase, done with err=0. SB of 0x12 → HWDATA=0x1212_1212.
- LW at misaligned 0xB000_0002, and separately LD on DATA_WIDTH=32 → HTRANS stays 00, cpu_done+cpu_err at T+1.
- LW with HREADY low for 3 data-phase cycles → done at T+6. HRESP=1 for two cycles (HREADY 0 then 1) → cpu_err=1. HREADY held low with TIMEOUT_CYCLES=16 → err after 16 low cycles, HTRANS=00.
- Assert reset during DATA → next cycle state IDLE, all outputs at reset values, no cpu_done. The next LW completes normally.
